store_buffer: RTL
=================

# store_buffer

Word-granular store buffer placed directly upstream of the data memory. It accepts store requests from the datapath, queues them in a small FIFO, and drains them into the data memory's single-write port on cycles with no load. Loads always get the memory port first. A load returns the youngest buffered data for its word, or the memory read data when no entry matches. The buffer raises `stall` when it cannot accept a store or a load.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries; must be a power of two, 2..16.

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all buffer state immediately.
- `st_req`  in  1  store request from datapath this cycle.
- `st_addr`  in  32  store byte address; only bits [11:2] are kept.
- `st_wd`  in  32  store data.
- `st_pc`  in  32  PC of the store, carried to memory for the write log.
- `ld_req`  in  1  load request this cycle.
- `ld_addr`  in  32  load byte address; compared on bits [11:2].
- `ld_rd`  out  32  load result, combinational.
- `stall`  out  1  datapath must hold the current instruction; combinational.
- `empty`  out  1  no valid entries.
- `dm_we`  out  1  memory write enable.
- `dm_re`  out  1  memory read enable.
- `dm_addr`  out  32  memory address, as `{20'b0, word[9:0], 2'b00}`.
- `dm_wd`  out  32  memory write data.
- `dm_pc`  out  32  PC forwarded to memory.
- `dm_rd`  in  32  memory read data, combinational from `dm_addr`.

## Operation
State:
- Circular FIFO of `DEPTH` entries, each {word[9:0], data[31:0], pc[31:0]}.
- `head` and `tail` pointers of log2(`DEPTH`) bits; both wrap modulo `DEPTH`.
- `count` of log2(`DEPTH`)+1 bits.
- full = (`count` == `DEPTH`); `empty` = (`count` == 0).

Port arbitration, combinational each cycle:
- `ld_req`=1 and the load is serviceable:
  - `dm_re`=1, `dm_we`=0, `dm_addr` from `ld_addr`.
  - No drain this cycle.
- Otherwise, if `count`>0:
  - `dm_we`=1, `dm_re`=0.
  - `dm_addr`, `dm_wd` and `dm_pc` come from the head entry.
  - The head entry pops at the edge.
- Otherwise all `dm_*` outputs are 0.

Push:
- `st_req`=1 and not full: {`st_addr[11:2]`, `st_wd`, `st_pc`} is written at `tail` at the edge; `tail` increments.
- `st_req`=1 and full: `stall`=1 and no push. The drain still pops, so the store is accepted on the next edge.
- Push and pop on the same edge: `count` is unchanged and both pointers advance.

Load lookup:
- Compare `ld_addr[11:2]` against every valid entry.
- The youngest match (closest to `tail`) wins.
- No match: `ld_rd` = `dm_rd`.
- Only committed entries are searched. A store pushed on the same edge is not visible.
- Duplicate words may coexist in the buffer. They drain in order, so the last write wins in memory.

Simultaneous `st_req` and `ld_req`:
- The load is serviced.
- The store pushes if not full.
- `stall` follows the rules above.

## Timing
- Reset values (async, effective immediately):
  - `count`, `head`, `tail` = 0.
  - `empty`=1, `stall`=0, `dm_we`=0, `dm_re`=0.
  - `dm_addr`, `dm_wd`, `dm_pc` = 0.
  - `ld_rd` = `dm_rd` (no entries are valid).
- Reset asserted mid-drain: all queued stores are discarded and no further write occurs. Memory contents are not touched by this block.
- Store-to-memory latency:
  - Minimum 1 edge: pushed at edge N, written to memory at edge N+1 if no load occurs on cycle N+1.
  - Each load cycle delays draining by one cycle.
- `ld_rd`, `stall` and all `dm_*` outputs are purely combinational from state and current inputs. There are zero cycles of load latency.
- A sustained stream of loads with a full buffer and `st_req` held means `stall` stays high indefinitely. The datapath must tolerate this.

## Configuration
- `SB_FORWARD_EN` defined: load forwarding as described in Operation.
- `SB_FORWARD_EN` undefined: a load whose word matches any valid entry is not serviceable.
  - Raise `stall`=1 and do not drive `dm_re`.
  - The port drains the head entry instead.
  - The load completes in the first cycle with no matching entry, reading `dm_rd` directly.
  - `ld_rd` = `dm_rd` always.

## Test plan
- Reset, then store 0x11111111 to 0x00000010 with no loads after it:
  - `dm_we`=1 with `dm_addr`=0x10 and `dm_wd`=0x11111111 on the next cycle.
  - `empty`=1 after that edge.
- Four stores to 0x0, 0x4, 0x8, 0xC while `ld_req` is held high with `ld_addr`=0x100, then a fifth store:
  - `stall`=1 and `count`=4.
  - After `ld_req` drops, writes appear in order 0x0, 0x4, 0x8, 0xC.
  - The fifth store is accepted one cycle after the drain begins.
- Stores 0xAAAA0000 then 0xBBBB0000, both to 0x20, followed by a load of 0x20:
  - With `SB_FORWARD_EN`: `ld_rd`=0xBBBB0000 and `stall`=0.
  - Without it: `stall`=1 for 2 cycles, then `ld_rd`=0xBBBB0000 read from memory.
- Store to 0x1020, then a load of 0x0020 (aliasing word index):
  - Forwarded match on bits [11:2].
  - `ld_rd` returns the store data.
- `Reset` pulsed asynchronously between edges with 3 entries queued:
  - `empty`=1 and `dm_we`=0 immediately.
  - No memory write follows.
- Simultaneous `st_req` to 0x40 and `ld_req` of 0x40 on an empty buffer:
  - `ld_rd` = old memory value.
  - On the next cycle the write of 0x40 drains.

Source files
------------

// File: rtl/store_buffer_if.sv
// store_buffer_if: datapath and data-memory signals of the store buffer.
//   master: datapath/memory side (drives st_*, ld_req, ld_addr, dm_rd)
//   slave : store buffer side (drives ld_rd, stall, empty, dm_we, dm_re, dm_addr, dm_wd, dm_pc)
interface store_buffer_if;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_wd;
  logic [31:0] st_pc;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_rd;
  logic        stall;
  logic        empty;
  logic        dm_we;
  logic        dm_re;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;
  modport master (
    output st_req, st_addr, st_wd, st_pc, ld_req, ld_addr, dm_rd,
    input  ld_rd, stall, empty, dm_we, dm_re, dm_addr, dm_wd, dm_pc
  );
  modport slave (
    input  st_req, st_addr, st_wd, st_pc, ld_req, ld_addr, dm_rd,
    output ld_rd, stall, empty, dm_we, dm_re, dm_addr, dm_wd, dm_pc
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: word-granular store FIFO in front of a single-port data memory.
//   Clk, Reset (async, active-high) plain ports; everything else on sb (store_buffer_if.slave):
//   st_req/st_addr/st_wd/st_pc store in, ld_req/ld_addr load in, ld_rd load result,
//   stall/empty status, dm_we/dm_re/dm_addr/dm_wd/dm_pc/dm_rd memory port.
//   Optional macro SB_FORWARD_EN: forward buffered data to loads instead of stalling them.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic     Clk,
  input logic     Reset,
  store_buffer_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [9:0]       word_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [AW:0]      count;
  logic [DEPTH-1:0] match;
  logic [9:0]       ld_word;
  logic             full, hit, ld_ok, push, pop;
  logic             unused;
  assign unused  = ^{sb.st_addr[31:12], sb.st_addr[1:0], sb.ld_addr[31:12], sb.ld_addr[1:0]};
  assign ld_word = sb.ld_addr[11:2];
  // match is indexed by age: bit 0 is the head (oldest), higher bits are younger
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = ((AW+1)'(i) < count) && (word_q[head + AW'(i)] == ld_word);
  end
  assign hit = |match;
`ifdef SB_FORWARD_EN
  logic [31:0] hit_data;
  // later (younger) matches override earlier ones
  always_comb begin
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (match[i]) hit_data = data_q[head + AW'(i)];
  end
  assign ld_ok    = sb.ld_req;
  assign sb.ld_rd = hit ? hit_data : sb.dm_rd;
`else
  // a load hitting a buffered word waits until that word has drained
  assign ld_ok    = sb.ld_req && !hit;
  assign sb.ld_rd = sb.dm_rd;
`endif
  assign full       = count == FULL;
  assign sb.empty   = count == '0;
  assign pop        = !ld_ok && !sb.empty;
  assign push       = sb.st_req && !full;
  assign sb.stall   = (sb.st_req && full) || (sb.ld_req && !ld_ok);
  assign sb.dm_we   = pop;
  assign sb.dm_re   = ld_ok;
  assign sb.dm_addr = ld_ok ? {20'b0, ld_word, 2'b00} : pop ? {20'b0, word_q[head], 2'b00} : '0;
  assign sb.dm_wd   = pop ? data_q[head] : '0;
  assign sb.dm_pc   = pop ? pc_q[head] : '0;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge Clk)
    if (push) begin
      word_q[tail] <= sb.st_addr[11:2];
      data_q[tail] <= sb.st_wd;
      pc_q[tail]   <= sb.st_pc;
    end
endmodule
